// File: rtl/usb_tx_ctrl_if.sv
// Handshake bundle between the packet-level TX logic / shift register and the
// USB full-speed transmit sequencer.
interface usb_tx_ctrl_if;
    logic       tx_start;
    logic [6:0] byte_count;
    logic       tx_out;
    logic       load_enable;
    logic       tx_shift;
    logic       tx_enable;
    logic [1:0] byte_sel;
    logic       get_byte;
    logic       stuff_bit;
    logic       eop;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start, byte_count, tx_out,
        input  load_enable, tx_shift, tx_enable, byte_sel, get_byte,
               stuff_bit, eop, tx_busy, tx_done
    );

    modport slave (
        input  tx_start, byte_count, tx_out,
        output load_enable, tx_shift, tx_enable, byte_sel, get_byte,
               stuff_bit, eop, tx_busy, tx_done
    );
endinterface

// File: rtl/usb_tx_ctrl.sv
// USB full-speed transmit sequencer: SYNC/PID/payload byte loading, bit timing,
// bit stuffing after six ones, EOP framing and inter-packet gap.
module usb_tx_ctrl #(
    parameter int CLKS_PER_BIT = 8
) (
    input logic         clk,
    input logic         n_rst,
    usb_tx_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP, GAP} state_t;

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    state_t        r_state;
    state_t        w_nextState;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bitCnt;
    logic [2:0]    r_ones;
    logic [6:0]    r_byteCount;
    logic [6:0]    r_payCnt;

    logic       w_start;
    logic       w_boundary;
    logic       w_inTx;
    logic       w_stuff;
    logic [2:0] w_nextOnes;
    logic       w_act;
    logic       w_byteEnd;
    logic       w_moreBytes;
    logic       w_load;
    logic       w_shift;
    logic [1:0] w_loadSel;

    assign w_start    = (r_state == IDLE) && bus.tx_start;
    assign w_boundary = (r_timer == LAST_TICK);
    assign w_inTx     = (r_state == SYNC) || (r_state == PID) || (r_state == DATA);
    assign w_stuff    = w_inTx && (r_ones == 3'd6);
    assign w_nextOnes = bus.tx_out ? r_ones + 3'd1 : 3'd0;

    // A data boundary that completes a six-ones run defers its action until the
    // end of the following stuff period; by then the bit counter has already
    // advanced, so a wrapped counter (0) marks a deferred end-of-byte.
    assign w_act     = w_inTx && w_boundary && (w_stuff || (w_nextOnes != 3'd6));
    assign w_byteEnd = w_stuff ? (r_bitCnt == 3'd0) : (r_bitCnt == 3'd7);
    assign w_load    = w_start || (w_act && w_byteEnd && w_moreBytes);
    assign w_shift   = w_act && !w_byteEnd;
    assign w_loadSel = (r_state == IDLE) ? 2'd0 : (r_state == SYNC) ? 2'd1 : 2'd2;

    always_comb begin
        w_moreBytes = 1'b0;
        case (r_state)
            SYNC:    w_moreBytes = 1'b1;
            PID:     w_moreBytes = (r_byteCount != 7'd0);
            DATA:    w_moreBytes = (r_payCnt != r_byteCount);
            default: w_moreBytes = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_timer     <= '0;
            r_bitCnt    <= 3'd0;
            r_ones      <= 3'd0;
            r_byteCount <= 7'd0;
            r_payCnt    <= 7'd0;
        end else if (w_start) begin
            r_timer     <= '0;
            r_bitCnt    <= 3'd0;
            r_ones      <= 3'd0;
            r_payCnt    <= 7'd0;
            r_byteCount <= bus.byte_count;
        end else if (r_state != IDLE) begin
            r_timer <= w_boundary ? '0 : r_timer + 1'b1;
            if (w_boundary && !w_stuff) begin
                r_bitCnt <= r_bitCnt + 3'd1;
            end
            if (w_inTx && w_boundary) begin
                r_ones <= w_stuff ? 3'd0 : w_nextOnes;
            end
            if (w_load && (w_loadSel == 2'd2)) begin
                r_payCnt <= r_payCnt + 7'd1;
            end
        end
    end

    // EOP is always entered with the bit counter at 0, so it doubles as the
    // two-period EOP counter.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_start) w_nextState = SYNC;
            SYNC, PID, DATA: begin
                if (w_act && w_byteEnd) begin
                    if (!w_moreBytes)          w_nextState = EOP;
                    else if (r_state == SYNC)  w_nextState = PID;
                    else                       w_nextState = DATA;
                end
            end
            EOP: if (w_boundary && (r_bitCnt == 3'd1)) w_nextState = GAP;
            GAP: if (w_boundary) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.load_enable = w_load;
        bus.byte_sel    = w_load ? w_loadSel : 2'd0;
        bus.get_byte    = w_load && (w_loadSel == 2'd2);
        bus.tx_shift    = w_shift;
        bus.tx_enable   = w_inTx;
        bus.stuff_bit   = w_stuff;
        bus.eop         = (r_state == EOP);
        bus.tx_busy     = (r_state != IDLE);
        bus.tx_done     = (r_state == GAP) && w_boundary;
    end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Scoreboard bench for usb_tx_ctrl: stimulus queues expected control events,
// a monitor pops and compares them as the sequencer produces them.
module tb_usb_tx_ctrl;

    localparam int KLOAD  = 0;
    localparam int KSTUFF = 1;
    localparam int KEOP   = 2;
    localparam int KDONE  = 3;

    typedef struct {
        int kind;
        int off;
        int sel;
        int shifts;
    } exp_t;

    logic clk;
    logic n_rst;
    usb_tx_ctrl_if bus ();

    usb_tx_ctrl #(.CLKS_PER_BIT(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    exp_t       expQ[$];
    logic [7:0] fifo[$];
    logic [7:0] pidReg;
    logic [7:0] sr;
    int         cyc;
    int         base;
    int         shiftCnt;
    int         checks;
    int         errors;
    logic       prevStuff;
    logic       prevEop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmit shift register and show-ahead FIFO model, LSB on the line first.
    assign bus.tx_out = sr[0];
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr <= 8'h00;
        end else if (bus.load_enable) begin
            case (bus.byte_sel)
                2'd0:    sr <= 8'h80;
                2'd1:    sr <= pidReg;
                default: sr <= (fifo.size() > 0) ? fifo[0] : 8'h00;
            endcase
            if (bus.get_byte && fifo.size() > 0) fifo.pop_front();
        end else if (bus.tx_shift) begin
            sr <= {1'b0, sr[7:1]};
        end
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc - base);
        end
    endtask

    task automatic handleEvent(input int kind);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpected_event", kind, -1);
            return;
        end
        e = expQ.pop_front();
        checkOutput("event_kind", kind, e.kind);
        checkOutput("event_cycle", cyc - base, e.off);
        if (kind == KLOAD) begin
            checkOutput("byte_sel", int'(bus.byte_sel), e.sel);
            checkOutput("get_byte", int'(bus.get_byte), int'(e.sel == 2));
            checkOutput("load_without_shift", int'(bus.tx_shift), 0);
        end
        if (kind == KDONE) begin
            checkOutput("shift_count", shiftCnt, e.shifts);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.load_enable && bus.byte_sel == 2'd0) begin
                base     = cyc;
                shiftCnt = 0;
            end
            if (bus.tx_shift) shiftCnt++;
            if (bus.load_enable) handleEvent(KLOAD);
            if (bus.stuff_bit && !prevStuff) handleEvent(KSTUFF);
            if (bus.eop && !prevEop) handleEvent(KEOP);
            if (bus.tx_done) handleEvent(KDONE);
        end
        prevStuff = bus.stuff_bit;
        prevEop   = bus.eop;
    end

    function automatic int outVec();
        return int'({bus.load_enable, bus.tx_shift, bus.tx_enable, bus.byte_sel,
                     bus.get_byte, bus.stuff_bit, bus.eop, bus.tx_busy, bus.tx_done});
    endfunction

    task automatic pushExp(input int kind, input int off, input int sel, input int shifts);
        exp_t e;
        e.kind   = kind;
        e.off    = off;
        e.sel    = sel;
        e.shifts = shifts;
        expQ.push_back(e);
    endtask

    // Sends one packet; resetAt > 0 aborts it with n_rst at that cycle offset,
    // extraAt > 0 pulses tx_start again at that offset while busy.
    task automatic applyStimulus(input logic [7:0] pidV, input int n,
                                 input logic [7:0] b0, input logic [7:0] b1,
                                 input int stuffOff, input int eopOff, input int doneOff,
                                 input int shifts, input int extraAt, input int resetAt);
        int seen;
        int loadOffs[4];
        loadOffs = '{0, 64, 128, 192};
        for (int i = 0; i < 2 + n; i++) begin
            if (resetAt <= 0 || loadOffs[i] < resetAt)
                pushExp(KLOAD, loadOffs[i], (i < 2) ? i : 2, 0);
        end
        if (resetAt <= 0) begin
            if (stuffOff > 0) pushExp(KSTUFF, stuffOff, 0, 0);
            pushExp(KEOP, eopOff, 0, 0);
            pushExp(KDONE, doneOff, 0, shifts);
        end
        pidReg = pidV;
        if (n >= 1) fifo.push_back(b0);
        if (n >= 2) fifo.push_back(b1);
        @(posedge clk); #1;
        bus.tx_start   = 1'b1;
        bus.byte_count = 7'(n);
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        seen = 0;
        for (int c = 1; c < 400 && seen == 0; c++) begin
            bus.tx_start = (c == extraAt);
            if (c == resetAt) begin
                n_rst = 1'b0;
                #1;
                checkOutput("outputs_in_reset", outVec(), 0);
                fifo.delete();
                repeat (2) @(posedge clk);
                #1;
                n_rst = 1'b1;
                checkOutput("busy_after_reset", int'(bus.tx_busy), 0);
                checkOutput("queue_empty_after_reset", expQ.size(), 0);
                return;
            end
            @(negedge clk);
            if (bus.tx_done) seen = 1;
            @(posedge clk); #1;
        end
        bus.tx_start = 1'b0;
        checkOutput("tx_done_seen", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("busy_after_done", int'(bus.tx_busy), 0);
        checkOutput("queue_empty", expQ.size(), 0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        base           = 0;
        shiftCnt       = 0;
        cyc            = 0;
        pidReg         = 8'h00;
        n_rst          = 1'b0;
        bus.tx_start   = 1'b0;
        bus.byte_count = 7'd0;
        #7;
        checkOutput("outputs_at_reset", outVec(), 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        applyStimulus(8'hD2, 0, 8'h00, 8'h00, 0, 129, 152, 14, 0, 0);
        applyStimulus(8'h4B, 1, 8'h00, 8'h00, 0, 193, 216, 21, 0, 0);
        applyStimulus(8'hC3, 1, 8'hFF, 8'h00, 161, 201, 224, 21, 0, 0);
        applyStimulus(8'hC3, 1, 8'hFC, 8'h00, 193, 201, 224, 21, 0, 0);
        applyStimulus(8'h4B, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 150);
        applyStimulus(8'hD2, 0, 8'h00, 8'h00, 0, 129, 152, 14, 0, 0);
        applyStimulus(8'h4B, 1, 8'h00, 8'h00, 0, 193, 216, 21, 160, 0);
        applyStimulus(8'hD2, 0, 8'h00, 8'h00, 0, 129, 152, 14, 0, 0);
        applyStimulus(8'hD2, 0, 8'h00, 8'h00, 0, 129, 152, 14, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
